// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states, flag bit positions
// and the mul/div opcode classifier shared by alu_seq.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SLT    = 5'h06;
  localparam logic [4:0] OP_SLTU   = 5'h07;
  localparam logic [4:0] OP_SRL    = 5'h08;
  localparam logic [4:0] OP_SRA    = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam int F_DBZ  = 0;
  localparam int F_OVF  = 1;
  localparam int F_NEG  = 2;
  localparam int F_ZERO = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(
    input logic [4:0] opr
  );
    return opr[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request (in_*) and response (out_*) handshakes.
// master drives requests and out_ready; slave is the ALU.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_opr;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [3:0]      flag;
  logic            busy;

  modport master (
    output in_valid, alu_opr,
    output operand1, operand2,
    output out_ready,
    input  in_ready, out_valid,
    input  result, flag, busy
  );

  modport slave (
    input  in_valid, alu_opr,
    input  operand1, operand2,
    input  out_ready,
    output in_ready, out_valid,
    output result, flag, busy
  );
endinterface

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core: iterative shift-add multiply / restoring divide.
// Ports: start loads a/b/opr; done is high on the final edge with res/ovf/dbz.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [4:0]      opr,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic            ovf,
  output logic            dbz
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};

  logic              active;
  logic [CW-1:0]     cnt;
  logic [4:0]        op_q;
  logic              div_q;
  logic              neg_q;
  logic              neg_r;
  logic              zdiv_q;
  logic              ovf_q;
  logic [XLEN-1:0]   dvs_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] acc;

  logic              is_div;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   ma;
  logic [XLEN-1:0]   mb;

  // Work on magnitudes; the sign is reapplied at the end.
  always_comb begin
    is_div = opr[2];
    sa     = 1'b0;
    sb     = 1'b0;
    unique case (1'b1)
      (opr == OP_MUL),
      (opr == OP_MULH),
      (opr == OP_DIV),
      (opr == OP_REM): begin
        sa = a[XLEN-1];
        sb = b[XLEN-1];
      end
      (opr == OP_MULHSU): sa = a[XLEN-1];
      default: ;
    endcase
    ma = sa ? -a : a;
    mb = sb ? -b : b;
  end

  logic [XLEN:0]     msum;
  logic [XLEN:0]     rtry;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;

  // acc = {partial product | remainder, multiplier | quotient}
  always_comb begin
    msum = {1'b0, acc[2*XLEN-1:XLEN]}
         + (acc[0] ? {1'b0, dvs_q} : '0);
    rtry = acc[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    if (div_q)
      acc_nxt = {rtry[XLEN] ? acc[2*XLEN-2:XLEN-1]
                            : rtry[XLEN-1:0],
                 acc[XLEN-2:0], ~rtry[XLEN]};
    else
      acc_nxt = {msum, acc[XLEN-1:1]};
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rmd  = acc_nxt[2*XLEN-1:XLEN];
  end

  always_comb begin
    res = prod[XLEN-1:0];
    unique case (1'b1)
      (op_q == OP_MULH),
      (op_q == OP_MULHSU),
      (op_q == OP_MULHU):
        res = prod[2*XLEN-1:XLEN];
      (op_q == OP_DIV),
      (op_q == OP_DIVU):
        res = zdiv_q ? '1 : (neg_q ? -quo : quo);
      (op_q == OP_REM),
      (op_q == OP_REMU):
        res = zdiv_q ? a_q : (neg_r ? -rmd : rmd);
      default: ;
    endcase
  end

  assign done = active & (cnt == CW'(XLEN-1));
  assign ovf  = ovf_q;
  assign dbz  = zdiv_q;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      active <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      op_q   <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zdiv_q <= 1'b0;
      ovf_q  <= 1'b0;
      dvs_q  <= '0;
      a_q    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      op_q   <= opr;
      div_q  <= is_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      zdiv_q <= is_div && (b == '0);
      ovf_q  <= (opr == OP_DIV) && (a == MINV) && (&b);
      a_q    <= a;
      dvs_q  <= is_div ? mb : ma;
      acc    <= {{XLEN{1'b0}}, is_div ? ma : mb};
    end else if (active) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flag and M-extension.
// Ports: clk, rst, flush, bus (alu_seq_if.slave: in_*, out_*, result, flag, busy).
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_t          state;
  logic            out_v;
  logic [XLEN-1:0] res_q;
  logic [3:0]      flag_q;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            md_op;
  logic            accept;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] dif;
  logic [XLEN-1:0] base_res;
  logic            base_ovf;

  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic            md_ovf;
  logic            md_dbz;

  assign a      = bus.operand1;
  assign b      = bus.operand2;
  assign md_op  = is_muldiv(bus.alu_opr);
  // Ready in DONE when the result retires on this same edge.
  assign bus.in_ready =
    (state == S_IDLE) |
    ((state == S_DONE) & bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready & ~flush;

  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_v;
  assign bus.result    = res_q;
  assign bus.flag      = flag_q;

  always_comb begin
    sum      = a + b;
    dif      = a - b;
    base_res = a;
    base_ovf = 1'b0;
    unique case (1'b1)
      (bus.alu_opr == OP_ADD): begin
        base_res = sum;
        base_ovf = (a[XLEN-1] == b[XLEN-1]) &
                   (sum[XLEN-1] != a[XLEN-1]);
      end
      (bus.alu_opr == OP_SUB): begin
        base_res = dif;
        base_ovf = (a[XLEN-1] != b[XLEN-1]) &
                   (dif[XLEN-1] != a[XLEN-1]);
      end
      (bus.alu_opr == OP_AND): base_res = a & b;
      (bus.alu_opr == OP_OR):  base_res = a | b;
      (bus.alu_opr == OP_XOR): base_res = a ^ b;
      (bus.alu_opr == OP_SLL):
        base_res = a << b[SHW-1:0];
      (bus.alu_opr == OP_SLT):
        base_res = {{(XLEN-1){1'b0}},
                    $signed(a) < $signed(b)};
      (bus.alu_opr == OP_SLTU):
        base_res = {{(XLEN-1){1'b0}}, a < b};
      (bus.alu_opr == OP_SRL):
        base_res = a >> b[SHW-1:0];
      (bus.alu_opr == OP_SRA):
        base_res = $signed(a) >>> b[SHW-1:0];
      default: ;
    endcase
  end

  function automatic logic [3:0] mk_flag(
    input logic [XLEN-1:0] r,
    input logic            o,
    input logic            z
  );
    logic [3:0] f;
    f         = '0;
    f[F_ZERO] = (r == '0);
    f[F_NEG]  = r[XLEN-1];
    f[F_OVF]  = o;
    f[F_DBZ]  = z;
    return f;
  endfunction

  alu_muldiv_core #(.XLEN(XLEN)) u_md (
    .clk   (clk),
    .rst   (rst),
    .kill  (flush),
    .start (accept & md_op),
    .opr   (bus.alu_opr),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .res   (md_res),
    .ovf   (md_ovf),
    .dbz   (md_dbz)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state  <= S_IDLE;
      out_v  <= 1'b0;
      res_q  <= '0;
      flag_q <= '0;
    end else if (accept) begin
      if (md_op) begin
        state <= S_CALC;
        out_v <= 1'b0;
      end else begin
        state  <= S_DONE;
        out_v  <= 1'b1;
        res_q  <= base_res;
        flag_q <= mk_flag(base_res, base_ovf, 1'b0);
      end
    end else begin
      unique case (state)
        S_CALC:
          if (md_done) begin
            state  <= S_DONE;
            out_v  <= 1'b1;
            res_q  <= md_res;
            flag_q <= mk_flag(md_res, md_ovf, md_dbz);
          end
        S_DONE:
          if (bus.out_ready) begin
            state <= S_IDLE;
            out_v <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random ops against an arithmetic model;
// checks result, flag, latency, hold, flush and reset behaviour.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  alu_seq_if #(.XLEN(32)) bus ();

  alu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void ref_op(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [3:0]  f
  );
    longint sa, sb, ua, ub, t;
    logic [63:0] p;
    logic ov, dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ov = 1'b0;
    dz = 1'b0;
    r  = a;
    case (op)
      5'h00: begin
        t  = sa + sb;
        r  = 32'(t);
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'h01: begin
        t  = sa - sb;
        r  = 32'(t);
        ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = a << b[4:0];
      5'h06: r = (sa < sb) ? 32'd1 : 32'd0;
      5'h07: r = (ua < ub) ? 32'd1 : 32'd0;
      5'h08: r = a >> b[4:0];
      5'h09: r = 32'(sa >>> b[4:0]);
      5'h10: begin p = 64'(sa * sb); r = p[31:0]; end
      5'h11: begin p = 64'(sa * sb); r = p[63:32]; end
      5'h12: begin p = 64'(sa * ub); r = p[63:32]; end
      5'h13: begin p = 64'(ua * ub); r = p[63:32]; end
      5'h14:
        if (b == 0) begin r = '1; dz = 1'b1; end
        else begin
          t  = sa / sb;
          r  = 32'(t);
          ov = t > 64'sd2147483647;
        end
      5'h15:
        if (b == 0) begin r = '1; dz = 1'b1; end
        else r = 32'(ua / ub);
      5'h16:
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = 32'(sa % sb);
      5'h17:
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = 32'(ua % ub);
      default: r = a;
    endcase
    f = {r == 0, r[31], ov, dz};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 7));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, wait for out_valid, check latency/result/flag.
  task automatic run_op(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input string       tag
  );
    logic [31:0] er;
    logic [3:0]  ef;
    int w, lat, want;
    ref_op(op, a, b, er, ef);
    want = (op >= 5'h10 && op <= 5'h17) ? 33 : 1;
    bus.alu_opr  = op;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk($sformatf("%s wait", tag), w, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.alu_opr  = 5'($urandom);
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk($sformatf("%s op%0h lat", tag, op), lat, want);
    chk($sformatf("%s op%0h %0h,%0h res", tag, op, a, b),
        bus.result, er);
    chk($sformatf("%s op%0h %0h,%0h flag", tag, op, a, b),
        bus.flag, ef);
  endtask

  initial begin
    logic [31:0] held;
    bit          seen;
    logic [4:0]  ops [20];
    ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04,
            5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
            5'h10, 5'h11, 5'h12, 5'h13, 5'h14,
            5'h15, 5'h16, 5'h17, 5'h0A, 5'h1F};
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_opr   = '0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst result", bus.result, 0);
    chk("rst flag", bus.flag, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst in_ready", bus.in_ready, 1);

    run_op(5'h00, 32'h7FFF_FFFF, 32'h1, "add");
    chk("add res", bus.result, 32'h8000_0000);
    chk("add flag", bus.flag, 4'b0110);
    run_op(5'h09, 32'h8000_0000, 32'd4, "sra");
    chk("sra res", bus.result, 32'hF800_0000);
    run_op(5'h06, 32'hFFFF_FFFF, 32'd1, "slt");
    chk("slt res", bus.result, 32'd1);
    run_op(5'h07, 32'hFFFF_FFFF, 32'd1, "sltu");
    chk("sltu res", bus.result, 32'd0);
    run_op(5'h14, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div res", bus.result, 32'hFFFF_FFFD);
    run_op(5'h16, 32'hFFFF_FFF9, 32'd2, "rem");
    chk("rem res", bus.result, 32'hFFFF_FFFF);
    run_op(5'h15, 32'd5, 32'd0, "divu0");
    chk("divu0 res", bus.result, 32'hFFFF_FFFF);
    chk("divu0 dbz", bus.flag[0], 1);
    run_op(5'h16, 32'd5, 32'd0, "rem0");
    chk("rem0 res", bus.result, 32'd5);
    run_op(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    chk("divovf res", bus.result, 32'h8000_0000);
    chk("divovf ovf", bus.flag[1], 1);
    run_op(5'h11, 32'h8000_0000, 32'h8000_0000, "mulh");
    chk("mulh res", bus.result, 32'h4000_0000);
    run_op(5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    chk("mulhsu res", bus.result, 32'hFFFF_FFFF);
    run_op(5'h10, 32'd3, 32'hFFFF_FFFE, "mul");
    chk("mul res", bus.result, 32'hFFFF_FFFA);

    // Backpressure: hold result for 5 cycles, then accept on retire.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_op(5'h01, 32'd10, 32'd3, "hold");
    held = bus.result;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold result", bus.result, held);
      chk("hold valid", bus.out_valid, 1);
      chk("hold in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1 chk("retire in_ready", bus.in_ready, 1);
    run_op(5'h00, 32'd40, 32'd2, "b2b");
    chk("b2b res", bus.result, 32'd42);

    // Flush during CALC.
    bus.alu_opr  = 5'h14;
    bus.operand1 = 32'd100;
    bus.operand2 = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk("calc busy", bus.busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", bus.busy, 0);
    chk("flush valid", bus.out_valid, 0);
    chk("flush result", bus.result, 0);
    chk("flush flag", bus.flag, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush no result", seen, 0);

    // Request coinciding with flush is dropped.
    bus.alu_opr  = 5'h00;
    bus.operand1 = 32'd1;
    bus.operand2 = 32'd1;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush+req valid", bus.out_valid, 0);
    chk("flush+req busy", bus.busy, 0);

    // Flush in DONE discards the pending result.
    run_op(5'h03, 32'h00F0, 32'h0F00, "or");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flushdone valid", bus.out_valid, 0);
    chk("flushdone result", bus.result, 0);

    // Reset during CALC.
    run_op(5'h02, 32'hFF, 32'h0F, "and");
    bus.alu_opr  = 5'h10;
    bus.operand1 = 32'd9;
    bus.operand2 = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstcalc busy", bus.busy, 0);
    chk("rstcalc valid", bus.out_valid, 0);
    chk("rstcalc result", bus.result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rstcalc no result", seen, 0);

    for (int i = 0; i < 80; i++) begin
      run_op(ops[$urandom_range(0, 19)],
             pick(), pick(), "rand");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
